// File: rtl/hog_svm_pkg.sv
// Shared encodings and width helpers for the
// SVM detection result path.
package hog_svm_pkg;

    typedef enum logic [1:0] {
        LED_OFF    = 2'd0,
        LED_FRAME  = 2'd1,
        LED_HOLD   = 2'd2,
        LED_TOGGLE = 2'd3
    } led_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? clog2(n_ch) : 1;
    endfunction

    function automatic int ENT_W(input int n_ch, input int sw_w);
        return ch_w(n_ch) + 1 + sw_w;
    endfunction

endpackage

// File: rtl/det_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible
// on rdata whenever empty is low.
module det_fifo
    import hog_svm_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB separates full from empty.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/det_result_buffer.sv
// Collects per-channel SVM results, queues them for the host,
// counts positives per frame and drives the status LED.
module det_result_buffer #(
    parameter int N_CH     = 2,
    parameter int SW_W     = 11,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 12,
    parameter int HOLD_W   = 24,
    parameter int LED_HOLD = 12500000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_CH-1:0]                    i_valid,
    input  logic [N_CH-1:0]                    i_person,
    input  logic [N_CH*SW_W-1:0]               i_sw_id,
    input  logic                               store_all,
    input  logic [1:0]                         led_mode,
    input  logic                               frame_end,
    input  logic                               clr_ovf,
    output logic                               o_valid,
    input  logic                               o_ready,
    output logic [hog_svm_pkg::ch_w(N_CH)-1:0] o_ch,
    output logic                               o_person,
    output logic [SW_W-1:0]                    o_sw_id,
    output logic [CNT_W-1:0]                   frame_cnt,
    output logic                               o_ovf,
    output logic                               led
);

    localparam int CH_W  = hog_svm_pkg::ch_w(N_CH);
    localparam int EW    = hog_svm_pkg::ENT_W(N_CH, SW_W);
    localparam int SUM_W = CNT_W + 4;

    logic [N_CH-1:0]   pend_v, pend_p, cap, gnt, drop, load;
    logic [SW_W-1:0]   pend_id [N_CH];
    logic [CH_W-1:0]   rr_ptr, gnt_idx, hi_idx, lo_idx;
    logic              hi_any, lo_any, gnt_any;
    logic              fifo_full, fifo_empty;
    logic [EW-1:0]     push_data, head;
    logic [3:0]        inc;
    logic              any_pos;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  run_cnt, cnt_next, frame_next;
    logic [HOLD_W-1:0] timer, timer_next;
    logic              tog, tog_next, led_next;

    // Round robin: first pending at/after rr_ptr, else lowest.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (pend_v[c]) begin
                lo_any = 1'b1;
                lo_idx = CH_W'(c);
                if (c >= int'(rr_ptr)) begin
                    hi_any = 1'b1;
                    hi_idx = CH_W'(c);
                end
            end
        end
        gnt_any = !fifo_full && lo_any;
        gnt_idx = hi_any ? hi_idx : lo_idx;
    end

    always_comb begin
        cap  = '0;
        gnt  = '0;
        drop = '0;
        load = '0;
        inc  = '0;
        for (int c = 0; c < N_CH; c++) begin
            cap[c]  = i_valid[c] & (i_person[c] | store_all);
            gnt[c]  = gnt_any && (gnt_idx == CH_W'(c));
            drop[c] = cap[c] & pend_v[c] & ~gnt[c];
            load[c] = cap[c] & ~drop[c];
            if (load[c] && i_person[c]) inc = inc + 4'd1;
        end
        any_pos = (inc != 4'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_v <= '0;
            pend_p <= '0;
            rr_ptr <= '0;
            for (int c = 0; c < N_CH; c++) pend_id[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (load[c]) begin
                    pend_v[c]  <= 1'b1;
                    pend_p[c]  <= i_person[c];
                    pend_id[c] <= i_sw_id[c*SW_W +: SW_W];
                end else if (gnt[c]) begin
                    pend_v[c] <= 1'b0;
                end
            end
            if (gnt_any)
                rr_ptr <= (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign push_data = {gnt_idx, pend_p[gnt_idx], pend_id[gnt_idx]};

    det_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gnt_any),
        .wdata (push_data),
        .pop   (o_valid & o_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head fields are masked so the stream reads all-zero when idle.
    assign o_valid  = !fifo_empty;
    assign o_ch     = o_valid ? head[EW-1 -: CH_W] : '0;
    assign o_person = o_valid & head[SW_W];
    assign o_sw_id  = o_valid ? head[SW_W-1:0] : '0;

    assign sum        = SUM_W'(run_cnt) + SUM_W'(inc);
    assign cnt_next   = (sum[SUM_W-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];
    assign frame_next = frame_end ? cnt_next : frame_cnt;

    always_comb begin
        timer_next = timer;
        tog_next   = tog;
        led_next   = 1'b0;
        if (any_pos && led_mode == hog_svm_pkg::LED_HOLD)
            timer_next = HOLD_W'(LED_HOLD);
        else if (timer != '0)
            timer_next = timer - 1'b1;
        if (any_pos && led_mode == hog_svm_pkg::LED_TOGGLE)
            tog_next = ~tog;
        unique case (1'b1)
            led_mode == hog_svm_pkg::LED_FRAME:  led_next = (frame_next != '0);
            led_mode == hog_svm_pkg::LED_HOLD:   led_next = (timer_next != '0);
            led_mode == hog_svm_pkg::LED_TOGGLE: led_next = tog_next;
            default:                             led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt   <= '0;
            frame_cnt <= '0;
            o_ovf     <= 1'b0;
            timer     <= '0;
            tog       <= 1'b0;
            led       <= 1'b0;
        end else begin
            run_cnt   <= frame_end ? '0 : cnt_next;
            frame_cnt <= frame_next;
            if (|drop)
                o_ovf <= 1'b1;
            else if (clr_ovf)
                o_ovf <= 1'b0;
            timer <= timer_next;
            tog   <= tog_next;
            led   <= led_next;
        end
    end

endmodule

// File: tb/tb_det_result_buffer.sv
// Directed bench for det_result_buffer: ordering, overflow,
// filtering/counting, LED modes and async reset.
module tb_det_result_buffer;

    logic        clk;
    logic        rst;
    logic [1:0]  i_valid;
    logic [1:0]  i_person;
    logic [21:0] i_sw_id;
    logic        store_all;
    logic [1:0]  led_mode;
    logic        frame_end;
    logic        clr_ovf;
    logic        o_valid;
    logic        o_ready;
    logic [0:0]  o_ch;
    logic        o_person;
    logic [10:0] o_sw_id;
    logic [11:0] frame_cnt;
    logic        o_ovf;
    logic        led;

    int total = 0;
    int bad   = 0;

    det_result_buffer #(
        .N_CH     (2),
        .SW_W     (11),
        .DEPTH    (16),
        .CNT_W    (12),
        .HOLD_W   (24),
        .LED_HOLD (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_person  (i_person),
        .i_sw_id   (i_sw_id),
        .store_all (store_all),
        .led_mode  (led_mode),
        .frame_end (frame_end),
        .clr_ovf   (clr_ovf),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_ch      (o_ch),
        .o_person  (o_person),
        .o_sw_id   (o_sw_id),
        .frame_cnt (frame_cnt),
        .o_ovf     (o_ovf),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse0(input bit p, input int id);
        i_valid        = 2'b01;
        i_person       = {1'b0, p};
        i_sw_id[10:0]  = 11'(id);
        tick(1);
        i_valid = 2'b00;
    endtask

    task automatic pop_expect(input string tag, input int ch,
                              input bit p, input int id);
        check({tag, " valid"}, 32'(o_valid), 32'd1);
        check({tag, " ch"}, 32'(o_ch), 32'(ch));
        check({tag, " person"}, 32'(o_person), 32'(p));
        check({tag, " id"}, 32'(o_sw_id), 32'(id));
        o_ready = 1'b1;
        tick(1);
        o_ready = 1'b0;
    endtask

    bit pat [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        rst       = 1'b0;
        i_valid   = '0;
        i_person  = '0;
        i_sw_id   = '0;
        store_all = 1'b0;
        led_mode  = 2'd0;
        frame_end = 1'b0;
        clr_ovf   = 1'b0;
        o_ready   = 1'b0;
        #12;
        check("rst valid", 32'(o_valid), 32'd0);
        check("rst frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst ovf", 32'(o_ovf), 32'd0);
        check("rst led", 32'(led), 32'd0);
        check("rst id", 32'(o_sw_id), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick(1);

        // simultaneous pair with rr_ptr=0
        i_valid  = 2'b11;
        i_person = 2'b11;
        i_sw_id  = {11'd9, 11'd5};
        tick(1);
        i_valid = 2'b00;
        tick(1);
        pop_expect("pair0 a", 0, 1'b1, 5);
        pop_expect("pair0 b", 1, 1'b1, 9);
        check("pair0 empty", 32'(o_valid), 32'd0);

        // single ch0 moves rr_ptr to 1, next pair leads with ch1
        pulse0(1'b1, 1);
        tick(1);
        pop_expect("single", 0, 1'b1, 1);
        i_valid  = 2'b11;
        i_person = 2'b11;
        i_sw_id  = {11'd21, 11'd20};
        tick(1);
        i_valid = 2'b00;
        tick(1);
        pop_expect("pair1 a", 1, 1'b1, 21);
        pop_expect("pair1 b", 0, 1'b1, 20);
        check("pair1 empty", 32'(o_valid), 32'd0);

        // two-cycle latency
        pulse0(1'b1, 37);
        check("lat t+1", 32'(o_valid), 32'd0);
        tick(1);
        pop_expect("lat t+2", 0, 1'b1, 37);
        check("lat empty", 32'(o_valid), 32'd0);

        // overflow: 16 stored, 17th pending, 18th dropped
        for (int i = 0; i < 18; i++) begin
            pulse0(1'b1, 100 + i);
            tick(1);
            if (i == 16) check("ovf before drop", 32'(o_ovf), 32'd0);
        end
        check("ovf set", 32'(o_ovf), 32'd1);
        for (int i = 0; i < 17; i++)
            pop_expect("drain", 0, 1'b1, 100 + i);
        check("drain empty", 32'(o_valid), 32'd0);
        check("ovf sticky", 32'(o_ovf), 32'd1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf cleared", 32'(o_ovf), 32'd0);

        // 6 + 17 positives so far; the dropped one is not counted
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        check("frame_cnt 23", 32'(frame_cnt), 32'd23);

        // filtering with store_all=0
        for (int i = 0; i < 7; i++) begin
            pulse0(pat[i], 200 + i);
            tick(1);
        end
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        check("frame_cnt pos only", 32'(frame_cnt), 32'd4);
        for (int i = 0; i < 7; i++)
            if (pat[i]) pop_expect("filt", 0, 1'b1, 200 + i);
        check("filt empty", 32'(o_valid), 32'd0);

        // store_all=1 keeps negatives but counts positives only
        store_all = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pulse0(pat[i], 210 + i);
            tick(1);
        end
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        check("frame_cnt all", 32'(frame_cnt), 32'd4);
        for (int i = 0; i < 7; i++)
            pop_expect("all", 0, pat[i], 210 + i);
        check("all empty", 32'(o_valid), 32'd0);
        store_all = 1'b0;

        // LED modes
        o_ready  = 1'b1;
        led_mode = 2'd1;
        tick(1);
        check("led frame", 32'(led), 32'd1);
        led_mode = 2'd2;
        tick(1);
        check("led hold idle", 32'(led), 32'd0);
        pulse0(1'b1, 300);
        check("led hold t+1", 32'(led), 32'd1);
        tick(4);
        check("led hold t+5", 32'(led), 32'd1);
        pulse0(1'b1, 301);
        tick(5);
        check("led retrig t+11", 32'(led), 32'd1);
        tick(4);
        check("led retrig t+15", 32'(led), 32'd1);
        tick(1);
        check("led hold off t+16", 32'(led), 32'd0);
        led_mode = 2'd3;
        tick(1);
        check("led toggle idle", 32'(led), 32'd0);
        i_valid  = 2'b01;
        i_person = 2'b01;
        for (int k = 0; k < 3; k++) begin
            i_sw_id[10:0] = 11'(310 + k);
            tick(1);
            check("led toggle", 32'(led), 32'(k % 2 == 0));
        end
        i_valid = 2'b00;
        tick(3);
        check("led drained", 32'(o_valid), 32'd0);

        // async reset mid-burst with 5 queued entries
        o_ready  = 1'b0;
        led_mode = 2'd1;
        i_valid  = 2'b01;
        i_person = 2'b01;
        for (int k = 0; k < 5; k++) begin
            i_sw_id[10:0] = 11'(400 + k);
            tick(1);
        end
        i_valid = 2'b00;
        tick(2);
        check("burst head", 32'(o_sw_id), 32'd400);
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        check("burst frame_cnt", 32'(frame_cnt), 32'd10);
        check("burst led", 32'(led), 32'd1);
        i_valid       = 2'b01;
        i_sw_id[10:0] = 11'd500;
        #2 rst = 1'b0;
        #1;
        check("async valid", 32'(o_valid), 32'd0);
        check("async id", 32'(o_sw_id), 32'd0);
        check("async frame_cnt", 32'(frame_cnt), 32'd0);
        check("async led", 32'(led), 32'd0);
        i_valid = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        tick(2);
        check("post rst valid", 32'(o_valid), 32'd0);
        check("post rst frame_cnt", 32'(frame_cnt), 32'd0);
        check("post rst led", 32'(led), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
